// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Word-addressed data RAM behind a valid/ready request/response handshake.
//   One request (load or store) is accepted at a time; its response appears
//   LATENCY cycles after the accept edge and is held until taken.
//
//   Handshake semantics (both channels): a transfer happens on a rising clk
//   edge where valid and ready are both high. The responder keeps resp_valid
//   and resp_rdata stable until resp_ready is seen. req_ready is a pure
//   function of state (and reset) and never depends on req_valid.
//
//   Optional feature macro: BYTE_STROBE_EN adds req_wstrb[3:0], a per-byte
//   write enable for stores. Without it every store writes the full word.
//
//   state_dbg exposes the FSM state: 0 = IDLE, 1 = WAIT, 2 = RESP.
module data_memory_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef BYTE_STROBE_EN
  input  logic [3:0]  req_wstrb,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  input  logic [31:0] initial_values [0:DEPTH-1],
  output logic [31:0] memory_check [0:DEPTH-1],
  output logic [1:0]  state_dbg
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [31:0]       cap_rdata;
  logic [31:0]       mem [0:DEPTH-1];

  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic [31:0]       wr_word;
  logic [31:0]       load_data;

  // Address bits above the RAM index and the byte offset are ignored, so
  // addresses wrap modulo DEPTH words.
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

  assign idx       = req_addr[IDX_W+1:2];
  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign state_dbg = state;

  // Loads capture the RAM word as it stands before the accept edge; stores
  // respond with zero data.
  assign load_data = req_write ? 32'd0 : mem[idx];

  // Word to store: full word, or a byte-wise merge with the current contents.
  always_comb begin
    wr_word = req_wdata;
`ifdef BYTE_STROBE_EN
    for (int k = 0; k < 4; k++) begin
      wr_word[8*k +: 8] = req_wstrb[k] ? req_wdata[8*k +: 8] : mem[idx][8*k +: 8];
    end
`endif
  end

  // RAM: reload from initial_values on reset, otherwise write on store accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= initial_values[i];
      end
    end else if (accept && req_write) begin
      mem[idx] <= wr_word;
    end
  end

  // Combinational view of the RAM; a store shows up the cycle after accept.
  assign memory_check = mem;

  // Request/response FSM with registered resp_valid and resp_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      cap_rdata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_rdata <= load_data;
            if (LATENCY == 1) begin
              // Response appears directly in the cycle after accept.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= load_data;
            end else begin
              state <= WAIT;
              count <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (count == CNT_ONE) begin
            state      <= RESP;
            count      <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= cap_rdata;
          end else begin
            count <= count - CNT_ONE;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
          end
        end
        default: begin
          state      <= IDLE;
          count      <= '0;
          resp_valid <= 1'b0;
          resp_rdata <= 32'd0;
        end
      endcase
    end
  end

endmodule
